// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main controller: sequences fetch/decode/execute/memory/writeback.
// Latency: outputs are combinational from the registered state; 3-5 cycles per instruction when memory is ready.
// Backpressure: FETCH/MEMRD/MEMWR hold until mem_ready; a bounded wait pulses mem_timeout and returns to FETCH.
module mips_multicycle_ctrl #(
  parameter int STATE_W      = 4,
  parameter int MEM_WAIT_MAX = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pcen,
  output logic               iord,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [2:0]         alucontrol,
  output logic               illegal_op,
  output logic               mem_timeout,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_WAIT_MAX);

  state_t     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       pcwrite, branch, irwrite_i, memwrite_i;
  logic       mem_state, timeout;

  // State register and memory-wait counter; reset abandons any instruction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state and per-state control decode; a timeout overrides everything with a write-free return to FETCH.
  always_comb begin
    state_d     = state_q;
    pcwrite     = 1'b0;
    branch      = 1'b0;
    irwrite_i   = 1'b0;
    memwrite_i  = 1'b0;
    iord        = 1'b0;
    regdst      = 1'b0;
    memtoreg    = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    pcsrc       = 2'b00;
    alucontrol  = 3'b000;
    illegal_op  = 1'b0;
    mem_timeout = 1'b0;

    mem_state = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
    timeout   = mem_state && (wait_q == WAIT_LIMIT);

    case (state_q)
      FETCH: begin
        alusrcb    = 2'b01;
        alucontrol = ALU_ADD;
        if (mem_ready) begin
          irwrite_i = 1'b1;
          pcwrite   = 1'b1;
          state_d   = DECODE;
        end
      end
      DECODE: begin
        alusrcb    = 2'b11;
        alucontrol = ALU_ADD;
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYP:      state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
          default: begin
            illegal_op = 1'b1;
            state_d    = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = ALU_ADD;
        state_d    = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        state_d  = FETCH;
      end
      MEMWR: begin
        iord = 1'b1;
        if (mem_ready) begin
          memwrite_i = 1'b1;
          state_d    = FETCH;
        end
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        state_d = RTYPEWB;
        case (funct)
          6'b100000: alucontrol = ALU_ADD;
          6'b100010: alucontrol = ALU_SUB;
          6'b100100: alucontrol = ALU_AND;
          6'b100101: alucontrol = ALU_OR;
          6'b101010: alucontrol = ALU_SLT;
          default: begin
            alucontrol = ALU_ADD;
            illegal_op = 1'b1;
            state_d    = FETCH;
          end
        endcase
      end
      RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        state_d  = FETCH;
      end
      BEQEX: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        branch     = 1'b1;
        pcsrc      = 2'b01;
        state_d    = FETCH;
      end
      ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = ALU_ADD;
        state_d    = ADDIWB;
      end
      ADDIWB: begin
        regwrite = 1'b1;
        state_d  = FETCH;
      end
      JEX: begin
        pcwrite = 1'b1;
        pcsrc   = 2'b10;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase

    if (timeout) begin
      irwrite_i   = 1'b0;
      pcwrite     = 1'b0;
      memwrite_i  = 1'b0;
      mem_timeout = 1'b1;
      state_d     = FETCH;
    end

    // Counter restarts on every state change so each memory state gets a fresh budget.
    if (timeout || (state_d != state_q)) wait_d = 8'd0;
    else if (mem_state && !mem_ready)    wait_d = wait_q + 8'd1;
    else                                 wait_d = wait_q;
  end

  // Write strobes are held off while reset is asserted.
  assign pcen     = reset & (pcwrite | (branch & zero));
  assign irwrite  = reset & irwrite_i;
  assign memwrite = reset & memwrite_i;
  assign state    = STATE_W'(state_q);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for the multicycle MIPS controller: directed instruction sequences with a per-cycle scoreboard.
// Latency: one expected record per cycle, checked mid-cycle by an independent monitor.
// Backpressure: mem_ready stalls and timeout are exercised explicitly.
module tb_mips_multicycle_ctrl;

  localparam int WMAX = 12;

  // Column order: pcen iord memwrite irwrite | regdst memtoreg regwrite alusrca | alusrcb | pcsrc | alucontrol | illegal_op mem_timeout
  typedef logic [16:0] ctl_t;
  localparam ctl_t C_FGO   = 17'b1001_0000_01_00_010_00;
  localparam ctl_t C_FWAIT = 17'b0000_0000_01_00_010_00;
  localparam ctl_t C_FTO   = 17'b0000_0000_01_00_010_01;
  localparam ctl_t C_DEC   = 17'b0000_0000_11_00_010_00;
  localparam ctl_t C_DECI  = 17'b0000_0000_11_00_010_10;
  localparam ctl_t C_MADR  = 17'b0000_0001_10_00_010_00;
  localparam ctl_t C_MRD   = 17'b0100_0000_00_00_000_00;
  localparam ctl_t C_MRDTO = 17'b0100_0000_00_00_000_01;
  localparam ctl_t C_MWB   = 17'b0000_0110_00_00_000_00;
  localparam ctl_t C_MWRW  = 17'b0100_0000_00_00_000_00;
  localparam ctl_t C_MWRG  = 17'b0110_0000_00_00_000_00;
  localparam ctl_t C_RSUB  = 17'b0000_0001_00_00_110_00;
  localparam ctl_t C_ROR   = 17'b0000_0001_00_00_001_00;
  localparam ctl_t C_RILL  = 17'b0000_0001_00_00_010_10;
  localparam ctl_t C_RWB   = 17'b0000_1010_00_00_000_00;
  localparam ctl_t C_BEQZ  = 17'b1000_0001_00_01_110_00;
  localparam ctl_t C_BEQN  = 17'b0000_0001_00_01_110_00;
  localparam ctl_t C_AEX   = 17'b0000_0001_10_00_010_00;
  localparam ctl_t C_AWB   = 17'b0000_0010_00_00_000_00;
  localparam ctl_t C_JEX   = 17'b1000_0000_00_10_000_00;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       illegal_op, mem_timeout;
  logic [3:0] state;

  logic [20:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;
  event        sample_now;

  mips_multicycle_ctrl #(.STATE_W(4), .MEM_WAIT_MAX(WMAX)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pcen(pcen), .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .alucontrol(alucontrol), .illegal_op(illegal_op),
    .mem_timeout(mem_timeout), .state(state)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs just after the edge and queue what the DUT must show this cycle.
  task automatic step(input logic rst, input logic mr, input logic z,
                      input logic [3:0] st, input ctl_t c, input string nm);
    @(posedge clk);
    #1;
    reset     = rst;
    mem_ready = mr;
    zero      = z;
    exp_q.push_back({st, c});
    name_q.push_back(nm);
  endtask

  // Monitor: pops one expectation per sample point and compares it against the DUT outputs.
  initial begin
    logic [20:0] got, want;
    string       nm;
    forever begin
      @(negedge clk or sample_now);
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        nm   = name_q.pop_front();
        got  = {state, pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                alusrcb, pcsrc, alucontrol, illegal_op, mem_timeout};
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL %s: state=%0d ctl=%b required state=%0d ctl=%b",
                   nm, got[20:17], got[16:0], want[20:17], want[16:0]);
        end
      end
    end
  end

  initial begin
    #2 reset = 1'b0;
    op = 6'b100011;
    // Reset held three cycles with memory ready: FETCH decode, write strobes suppressed.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 4'd0, C_FWAIT, "reset_fetch");

    // lw: 0,1,2,3,4
    step(1'b1, 1'b1, 1'b0, 4'd0, C_FGO,  "lw_fetch");
    step(1'b1, 1'b1, 1'b0, 4'd1, C_DEC,  "lw_decode");
    step(1'b1, 1'b1, 1'b0, 4'd2, C_MADR, "lw_memadr");
    step(1'b1, 1'b1, 1'b0, 4'd3, C_MRD,  "lw_memrd");
    step(1'b1, 1'b1, 1'b0, 4'd4, C_MWB,  "lw_memwb");

    // R-type sub then or
    op = 6'b000000; funct = 6'b100010;
    step(1'b1, 1'b1, 1'b0, 4'd0, C_FGO,  "sub_fetch");
    step(1'b1, 1'b1, 1'b0, 4'd1, C_DEC,  "sub_decode");
    step(1'b1, 1'b1, 1'b0, 4'd6, C_RSUB, "sub_ex");
    step(1'b1, 1'b1, 1'b0, 4'd7, C_RWB,  "sub_wb");
    funct = 6'b100101;
    step(1'b1, 1'b1, 1'b0, 4'd0, C_FGO,  "or_fetch");
    step(1'b1, 1'b1, 1'b0, 4'd1, C_DEC,  "or_decode");
    step(1'b1, 1'b1, 1'b0, 4'd6, C_ROR,  "or_ex");
    step(1'b1, 1'b1, 1'b0, 4'd7, C_RWB,  "or_wb");

    // Unsupported funct: one illegal pulse, no writeback
    funct = 6'b111111;
    step(1'b1, 1'b1, 1'b0, 4'd0, C_FGO,  "badfn_fetch");
    step(1'b1, 1'b1, 1'b0, 4'd1, C_DEC,  "badfn_decode");
    step(1'b1, 1'b1, 1'b0, 4'd6, C_RILL, "badfn_ex");

    // beq taken then not taken
    op = 6'b000100; funct = 6'd0;
    step(1'b1, 1'b1, 1'b0, 4'd0, C_FGO,  "beqz_fetch");
    step(1'b1, 1'b1, 1'b0, 4'd1, C_DEC,  "beqz_decode");
    step(1'b1, 1'b1, 1'b1, 4'd8, C_BEQZ, "beqz_ex");
    step(1'b1, 1'b1, 1'b0, 4'd0, C_FGO,  "beqn_fetch");
    step(1'b1, 1'b1, 1'b0, 4'd1, C_DEC,  "beqn_decode");
    step(1'b1, 1'b1, 1'b0, 4'd8, C_BEQN, "beqn_ex");

    // addi
    op = 6'b001000;
    step(1'b1, 1'b1, 1'b0, 4'd0,  C_FGO, "addi_fetch");
    step(1'b1, 1'b1, 1'b0, 4'd1,  C_DEC, "addi_decode");
    step(1'b1, 1'b1, 1'b0, 4'd9,  C_AEX, "addi_ex");
    step(1'b1, 1'b1, 1'b0, 4'd10, C_AWB, "addi_wb");

    // j
    op = 6'b000010;
    step(1'b1, 1'b1, 1'b0, 4'd0,  C_FGO, "j_fetch");
    step(1'b1, 1'b1, 1'b0, 4'd1,  C_DEC, "j_decode");
    step(1'b1, 1'b1, 1'b0, 4'd11, C_JEX, "j_ex");

    // sw with 4 memory wait cycles: 8 cycles total
    op = 6'b101011;
    step(1'b1, 1'b1, 1'b0, 4'd0, C_FGO,  "sw_fetch");
    step(1'b1, 1'b1, 1'b0, 4'd1, C_DEC,  "sw_decode");
    step(1'b1, 1'b1, 1'b0, 4'd2, C_MADR, "sw_memadr");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 4'd5, C_MWRW, "sw_wait");
    step(1'b1, 1'b1, 1'b0, 4'd5, C_MWRG, "sw_write");

    // Unsupported opcode
    op = 6'b111111;
    step(1'b1, 1'b1, 1'b0, 4'd0, C_FGO,  "badop_fetch");
    step(1'b1, 1'b1, 1'b0, 4'd1, C_DECI, "badop_decode");

    // Stuck memory in FETCH: WMAX wait cycles, one timeout pulse, then counting restarts
    for (int i = 0; i < WMAX; i++) step(1'b1, 1'b0, 1'b0, 4'd0, C_FWAIT, "fetch_wait");
    step(1'b1, 1'b0, 1'b0, 4'd0, C_FTO,   "fetch_timeout");
    step(1'b1, 1'b0, 1'b0, 4'd0, C_FWAIT, "fetch_after_to");

    // Stuck memory in MEMRD: timeout abandons the load without writeback
    op = 6'b100011;
    step(1'b1, 1'b1, 1'b0, 4'd0, C_FGO,  "lwto_fetch");
    step(1'b1, 1'b1, 1'b0, 4'd1, C_DEC,  "lwto_decode");
    step(1'b1, 1'b1, 1'b0, 4'd2, C_MADR, "lwto_memadr");
    for (int i = 0; i < WMAX; i++) step(1'b1, 1'b0, 1'b0, 4'd3, C_MRD, "lwto_wait");
    step(1'b1, 1'b0, 1'b0, 4'd3, C_MRDTO, "lwto_timeout");
    step(1'b1, 1'b1, 1'b0, 4'd0, C_FGO,   "lwto_refetch");

    // lw interrupted by async reset in MEMWB
    step(1'b1, 1'b1, 1'b0, 4'd1, C_DEC,  "lwrst_decode");
    step(1'b1, 1'b1, 1'b0, 4'd2, C_MADR, "lwrst_memadr");
    step(1'b1, 1'b1, 1'b0, 4'd3, C_MRD,  "lwrst_memrd");
    step(1'b1, 1'b1, 1'b0, 4'd4, C_MWB,  "lwrst_memwb");
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    exp_q.push_back({4'd0, C_FWAIT});
    name_q.push_back("async_reset_memwb");
    -> sample_now;
    step(1'b0, 1'b1, 1'b0, 4'd0, C_FWAIT, "reset_hold");
    step(1'b1, 1'b1, 1'b0, 4'd0, C_FGO,   "restart_fetch");
    step(1'b1, 1'b1, 1'b0, 4'd1, C_DEC,   "restart_decode");

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
